// File: rtl/usb_keyboard_report_decoder.sv
// usb_keyboard_report_decoder: diffs each boot-keyboard report against the last committed one and emits press/release events
module usb_keyboard_report_decoder #(
  parameter MOD_EVENTS = "TRUE"
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rpt_sot,
  input  logic [7:0] rpt_data,
  input  logic       rpt_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_press,
  output logic [7:0] evt_code,
  output logic [7:0] modifiers,
  output logic       busy,
  output logic       report_done,
  output logic       err_rollover,
  output logic       err_overrun
);
  typedef enum logic [2:0] {S_IDLE, S_MOD, S_REL, S_PRS, S_COMMIT} state_t;
  localparam logic MOD_EN = (MOD_EVENTS == "TRUE");
  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] nmod_q, mod_q;
  logic [7:0] nk_q [6];
  logic [7:0] ok_q [6];
  logic       evt_valid_q, evt_valid_d, evt_press_q, evt_press_d;
  logic [7:0] evt_code_q, evt_code_d;
  logic       done_q, roll_q, ovr_q;
  logic [3:0] idx;
  logic       take, last, roll;
  logic [7:0] old_k, new_k, code;
  logic       rel_ev, prs_ev, has, press, adv, last_step;

  assign busy         = state_q != S_IDLE;
  assign evt_valid    = evt_valid_q;
  assign evt_press    = evt_press_q;
  assign evt_code     = evt_code_q;
  assign modifiers    = mod_q;
  assign report_done  = done_q;
  assign err_rollover = roll_q;
  assign err_overrun  = ovr_q;

  // byte indexing: sot restarts at byte0, accepted bytes advance, byte7 acceptance triggers the rollover test
  always_comb begin
    idx = rpt_sot ? 4'd0 : cnt_q;
    take = rpt_valid && !busy && !idx[3];
    last = take && idx == 4'd7;
    cnt_d = take ? idx + 4'd1 : idx;
    roll = rpt_data == 8'h01;
    for (int i = 0; i < 5; i++) roll = roll || nk_q[i] == 8'h01;
  end

  // qualify the current slot: releases skip keys still held or already released, presses skip keys already down
  always_comb begin
    old_k = 8'd0;
    new_k = 8'd0;
    for (int j = 0; j < 6; j++) begin
      if (3'(j) == step_q) begin
        old_k = ok_q[j];
        new_k = nk_q[j];
      end
    end
    rel_ev = old_k != 8'd0;
    prs_ev = new_k != 8'd0;
    for (int j = 0; j < 6; j++) begin
      if (nk_q[j] == old_k || (3'(j) < step_q && ok_q[j] == old_k)) rel_ev = 1'b0;
      if (ok_q[j] == new_k || (3'(j) < step_q && nk_q[j] == new_k)) prs_ev = 1'b0;
    end
  end

  // scan sequencing and event output register; an event step waits for a free output slot
  always_comb begin
    has = state_q == S_MOD ? nmod_q[step_q] != mod_q[step_q] : state_q == S_REL ? rel_ev : state_q == S_PRS && prs_ev;
    press = state_q == S_MOD ? nmod_q[step_q] : state_q == S_PRS;
    code = state_q == S_MOD ? {5'b11100, step_q} : state_q == S_REL ? old_k : new_k;
    adv = !has || !evt_valid_q || evt_ready;
    last_step = step_q == (state_q == S_MOD ? 3'd7 : 3'd5);
    state_d = state_q;
    step_d = step_q;
    evt_valid_d = evt_valid_q && !evt_ready;
    evt_press_d = evt_press_q;
    evt_code_d = evt_code_q;
    if (has && adv) begin
      evt_valid_d = 1'b1;
      evt_press_d = press;
      evt_code_d = code;
    end
    case (state_q)
      S_IDLE: if (last && !roll) state_d = MOD_EN ? S_MOD : S_REL;
      S_MOD, S_REL, S_PRS: begin
        if (adv) begin
          step_d = last_step ? 3'd0 : step_q + 3'd1;
          if (last_step) state_d = state_q == S_MOD ? S_REL : state_q == S_REL ? S_PRS : S_COMMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control, handshake and status pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      step_q <= 3'd0;
      cnt_q <= 4'd0;
      evt_valid_q <= 1'b0;
      evt_press_q <= 1'b0;
      evt_code_q <= 8'd0;
      done_q <= 1'b0;
      roll_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_press_q <= evt_press_d;
      evt_code_q <= evt_code_d;
      done_q <= state_q == S_COMMIT;
      roll_q <= last && roll;
      ovr_q <= rpt_valid && busy;
    end
  end

  // incoming report capture and the committed key/modifier state it is diffed against
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nmod_q <= 8'd0;
      mod_q <= 8'd0;
      for (int i = 0; i < 6; i++) begin
        nk_q[i] <= 8'd0;
        ok_q[i] <= 8'd0;
      end
    end else begin
      if (take && idx == 4'd0) nmod_q <= rpt_data;
      for (int i = 0; i < 6; i++) if (take && idx == 4'(i + 2)) nk_q[i] <= rpt_data;
      if (state_q == S_COMMIT) begin
        mod_q <= nmod_q;
        ok_q <= nk_q;
      end
    end
  end
endmodule

// File: doc/usb_keyboard_report_decoder.md
USB_KEYBOARD_REPORT_DECODER -- requirements
Module: usb_keyboard_report_decoder

Interface
REQ-001 Parameter MOD_EVENTS, default "TRUE", emits modifier-bit change events; "FALSE" skips the modifier scan.
REQ-002 Port clk  input  1  single clock, 60MHz; all logic on the rising edge.
REQ-003 Port rstn  input  1  asynchronous, active-low reset.
REQ-004 Port rpt_sot  input  1  one-cycle pulse marking the start of an incoming report packet.
REQ-005 Port rpt_data  input  8  report byte.
REQ-006 Port rpt_valid  input  1  rpt_data is valid this cycle; there is no backpressure.
REQ-007 Port evt_valid  output  1  key event available.
REQ-008 Port evt_ready  input  1  consumer accepts the event when evt_valid=1 and evt_ready=1.
REQ-009 Port evt_press  output  1  1=press, 0=release.
REQ-010 Port evt_code  output  8  HID usage code; modifiers map to 8'hE0+bit.
REQ-011 Port modifiers  output  8  committed modifier byte.
REQ-012 Port busy  output  1  a scan is in progress.
REQ-013 Port report_done  output  1  one-cycle pulse when a report is committed.
REQ-014 Port err_rollover  output  1  one-cycle pulse when a report is discarded for phantom/rollover.
REQ-015 Port err_overrun  output  1  one-cycle pulse when a byte is dropped because busy=1.

Function
REQ-016 Report format (boot keyboard):
- byte0 = modifiers.
- byte1 = reserved, ignored.
- bytes2-7 = six keycode slots K0..K5.
REQ-017 Byte collection:
- rpt_sot clears the byte counter to 0.
- Each rpt_valid byte with busy=0 is stored at the counter index; the counter then increments.
- Bytes beyond index 7 are ignored until the next rpt_sot.
- rpt_sot and rpt_valid in the same cycle: the byte is stored as byte0.
REQ-018 A packet that receives a new rpt_sot before byte7 is discarded silently; no state changes.
REQ-019 Rollover handling:
- On byte7 acceptance in cycle N, if any K slot equals 8'h01, the report is discarded.
- err_rollover pulses in cycle N+1.
- Committed state is unchanged.
REQ-020 Otherwise, in cycle N+1, busy=1 and the FSM enters MOD (or REL when MOD_EVENTS="FALSE").
REQ-021 FSM states and transitions: IDLE -> MOD (8 steps) -> REL (6 steps) -> PRS (6 steps) -> COMMIT -> IDLE.
REQ-022 MOD step i (0..7): emits an event when new modifier bit i differs from committed bit i.
- evt_press = new bit value.
- evt_code = 8'hE0+i.
REQ-023 REL step i: emits a release of old slot i when:
- the slot is nonzero,
- it is not equal to any new slot, and
- it is not equal to an earlier old slot.
REQ-024 PRS step i: emits a press of new slot i when:
- the slot is nonzero,
- it is not equal to any old slot, and
- it is not equal to an earlier new slot.
REQ-025 Step timing:
- A step with no event takes exactly one cycle.
- A step with an event advances only when the output register is free (evt_valid=0, or evt_ready=1 in that cycle).
- The event is loaded into the output register in that same cycle.
REQ-026 Output handshake:
- evt_valid, evt_press and evt_code are registered.
- They hold stable while evt_valid=1 and evt_ready=0.
- evt_valid deasserts the cycle after acceptance unless a new event is loaded.
REQ-027 COMMIT (one cycle):
- old slots <= new slots.
- modifiers <= new byte0.
- report_done pulses in the next cycle.
- busy returns to 0 in the next cycle.
REQ-028 Unstalled latency: byte7 in cycle N gives report_done at N+22 (MOD_EVENTS="TRUE") or N+14 (MOD_EVENTS="FALSE").
REQ-029 While busy=1:
- incoming rpt_valid bytes are dropped and each pulses err_overrun the next cycle;
- rpt_sot still clears the counter.
REQ-030 An identical repeated report produces no events but still commits and pulses report_done.

Reset
REQ-031 On rstn=0, asynchronously:
- FSM=IDLE.
- Byte counter=0.
- Old slots=0; modifiers=8'h00.
- evt_valid, evt_press and evt_code = 0.
- busy, report_done, err_rollover and err_overrun = 0.
REQ-032 Reset mid-scan or mid-packet discards all pending events and the partial report; the first post-reset report is compared against all-zero.

Verification
REQ-033 From reset, report 00 00 04 00 00 00 00 00 with evt_ready=1 -> single event press/8'h04; modifiers=00; report_done at N+22.
REQ-034 Then report 02 00 05 00 00 00 00 00 -> events in order: press/E1, release/04, press/05; modifiers=8'h02.
REQ-035 Report 00 00 01 01 01 01 01 01 -> err_rollover pulse; no events; modifiers and slots unchanged.
REQ-036 Report 00 00 06 06 00 00 00 00 with evt_ready held 0 for 10 cycles -> evt_valid=1 with press/06 stable throughout; exactly one 06 event; then scan completes.
REQ-037 Bytes sent while busy=1 -> one err_overrun pulse per byte; the committed result is unaffected; a packet cut short by rpt_sot after 5 bytes produces no events.
REQ-038 rstn pulsed low during REL with evt_valid=1 -> all outputs reach 0 immediately; re-sending the same report yields full press events.
